// File: rtl/imem_pkg.sv
// Shared types and limits for the instruction-memory fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    // Largest supported number of extra wait cycles between accept and response.
    localparam int MAX_WAIT_STATES = 15;

    // Width of the wait-state down-counter.
    localparam int WAIT_CNT_W = $clog2(MAX_WAIT_STATES + 1);

    // Fetch FSM states: at most one fetch is ever outstanding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x INSTR_W instruction storage, one synchronous read port and one write port.
// Latency: read data registered one cycle after rd_en.
// Backpressure: none; a same-index read and write in one cycle returns the old word.
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int INSTR_W = 32,
    parameter int IDX_W   = 10
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [INSTR_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [INSTR_W-1:0] wr_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Write port; contents are never touched by any reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port; non-blocking update keeps read-before-write ordering on a collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Single-outstanding instruction fetch controller over a preloadable instruction RAM.
// Latency: response valid exactly 1+WAIT_STATES cycles after request accept.
// Backpressure: response held stable until rsp_ready; req_ready only in IDLE without flush/reset.
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int                 ADDR_W      = 32,
    parameter int                 INSTR_W     = 32,
    parameter int                 DEPTH       = 1024,
    parameter int                 WAIT_STATES = 0,
    parameter logic [INSTR_W-1:0] ILLEGAL     = '0
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               srst,
    input  logic               flush,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [INSTR_W-1:0] rsp_instr,
    output logic               rsp_fault,
    input  logic               rsp_ready,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data
);

    // Byte-offset bits inside one instruction word, and RAM index width.
    localparam int OFF_W = $clog2(INSTR_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0]     OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [ADDR_W-1:0]     DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD  =
        WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    // An address is unusable if it is not word aligned or lies past the last word.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ((a & OFF_MASK) != '0) || ((a >> OFF_W) >= DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    imem_state_t             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q;
    logic                    fault_q;
    logic                    accept;
    logic                    enter_resp;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    rd_en;
    logic [INSTR_W-1:0]      rd_data;
    logic                    wr_ok;

    // State register, wait counter and latched fetch address/fault.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (srst) begin
                addr_q  <= '0;
                fault_q <= 1'b0;
            end else if (accept) begin
                addr_q  <= req_addr;
                fault_q <= addr_bad(req_addr);
            end
        end
    end

    // Next-state logic: srst beats everything, flush beats rsp_ready and new requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (srst) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        accept = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WS_LOAD;
                        end else begin
                            state_d = ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (flush || rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // With no wait states the RAM is read on the accept cycle, before addr_q is loaded.
    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign rd_addr    = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign rd_en      = enter_resp && !addr_bad(rd_addr);
    assign wr_ok      = wr_en && !addr_bad(wr_addr);

    imem_ram #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W),
        .IDX_W   (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (addr_idx(rd_addr)),
        .rd_data (rd_data),
        .wr_en   (wr_ok),
        .wr_idx  (addr_idx(wr_addr)),
        .wr_data (wr_data)
    );

    // Outputs decode straight from state so an async reset clears them at once.
    assign req_ready = (state_q == ST_IDLE) && !flush && !srst && !arst;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_fault = (state_q == ST_RESP) && fault_q;
    assign rsp_instr = ((state_q == ST_RESP) && !fault_q) ? rd_data : ILLEGAL;

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench: three controllers (0, 3 and 2 wait states) driven from tasks.
// Latency: checked per fetch against 1+WAIT_STATES.
// Backpressure: stall, flush and reset sequences exercised by hand.
module tb_imem_ctrl;

    localparam int          DEPTH     = 1024;
    localparam logic [31:0] ILL       = 32'h0;
    localparam int          WS_TAB[3] = '{0, 3, 2};

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        int          d;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    logic clk = 1'b0;
    logic [2:0]       arst, srst, flush, req_valid, req_ready;
    logic [2:0]       rsp_valid, rsp_fault, rsp_ready, wr_en;
    logic [2:0][31:0] req_addr, rsp_instr, wr_addr, wr_data;

    exp_t sb_q[$];
    vec_t vecs[11];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_ctrl #(
            .ADDR_W      (32),
            .INSTR_W     (32),
            .DEPTH       (DEPTH),
            .WAIT_STATES (WS_TAB[g]),
            .ILLEGAL     (ILL)
        ) u_dut (
            .clk       (clk),
            .arst      (arst[g]),
            .srst      (srst[g]),
            .flush     (flush[g]),
            .req_valid (req_valid[g]),
            .req_addr  (req_addr[g]),
            .req_ready (req_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_instr (rsp_instr[g]),
            .rsp_fault (rsp_fault[g]),
            .rsp_ready (rsp_ready[g]),
            .wr_en     (wr_en[g]),
            .wr_addr   (wr_addr[g]),
            .wr_data   (wr_data[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] v);
        wr_en[d]   = 1'b1;
        wr_addr[d] = a;
        wr_data[d] = v;
        tick();
        wr_en[d]   = 1'b0;
    endtask

    task automatic no_rsp(input int d, input int n, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            seen |= rsp_valid[d];
            tick();
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    // One complete fetch; optionally writes cdat to the same word on the RAM capture cycle.
    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] ei,
                         input logic ef, input logic cap, input logic [31:0] cdat);
        exp_t  e;
        int    lat;
        logic  leak;
        string tag;
        tag = $sformatf("d%0d_a%h", d, a);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        rsp_ready[d] = 1'b1;
        if (cap && WS_TAB[d] == 0) begin
            wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = cdat;
        end
        #1;
        check({tag, "_req_ready"}, {31'd0, req_ready[d]}, 32'd1);
        e.instr = ei;
        e.fault = ef;
        sb_q.push_back(e);
        tick();
        req_valid[d] = 1'b0;
        wr_en[d]     = 1'b0;
        lat  = 1;
        leak = 1'b0;
        while (!rsp_valid[d] && lat <= 20) begin
            leak |= req_ready[d];
            if (cap && lat == WS_TAB[d]) begin
                wr_en[d] = 1'b1; wr_addr[d] = a; wr_data[d] = cdat;
            end
            tick();
            wr_en[d] = 1'b0;
            lat++;
        end
        leak |= req_ready[d];
        check({tag, "_latency"}, lat, 1 + WS_TAB[d]);
        check({tag, "_ready_busy"}, {31'd0, leak}, 32'd0);
        e = sb_q.pop_front();
        check({tag, "_instr"}, rsp_instr[d], e.instr);
        check({tag, "_fault"}, {31'd0, rsp_fault[d]}, {31'd0, e.fault});
        tick();
        check({tag, "_valid_drop"}, {31'd0, rsp_valid[d]}, 32'd0);
        check({tag, "_idle_instr"}, rsp_instr[d], ILL);
    endtask

    initial begin
        arst = '1; srst = '0; flush = '0; req_valid = '0; rsp_ready = '0; wr_en = '0;
        req_addr = '0; wr_addr = '0; wr_data = '0;
        tick();
        tick();
        // Reset state while arst is still asserted
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid_d%0d", d), {31'd0, rsp_valid[d]}, 32'd0);
            check($sformatf("rst_fault_d%0d", d), {31'd0, rsp_fault[d]}, 32'd0);
            check($sformatf("rst_instr_d%0d", d), rsp_instr[d], ILL);
            check($sformatf("rst_ready_d%0d", d), {31'd0, req_ready[d]}, 32'd0);
        end
        arst = '0;
        #1;
        check("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);
        flush[0] = 1'b1;
        #1;
        check("ready_flush_idle", {31'd0, req_ready[0]}, 32'd0);
        flush[0] = 1'b0;
        tick();

        // Preload; the last two writes on dut0 are illegal and must not alias words 0 and 1
        wr(0, 32'h0000_0000, 32'h0000_0013);
        wr(0, 32'h0000_0004, 32'h1111_1111);
        wr(0, 32'h0000_0FFC, 32'hCAFE_F00D);
        wr(0, 32'h0000_0008, 32'h0BAD_C0DE);
        wr(0, 32'h0000_1000, 32'hBAD0_BAD0);
        wr(0, 32'h0000_0005, 32'hBAD1_BAD1);
        wr(1, 32'h0000_0004, 32'hDEAD_BEEF);
        wr(1, 32'h0000_0008, 32'h1234_5678);
        wr(2, 32'h0000_0010, 32'hA5A5_A5A5);

        vecs[0]  = '{0, 32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[1]  = '{0, 32'h0000_0004, 32'h1111_1111, 1'b0};
        vecs[2]  = '{0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
        vecs[3]  = '{0, 32'h0000_0002, ILL,           1'b1};
        vecs[4]  = '{0, 32'h0000_1000, ILL,           1'b1};
        vecs[5]  = '{0, 32'h0000_0FFF, ILL,           1'b1};
        vecs[6]  = '{0, 32'hFFFF_FFFC, ILL,           1'b1};
        vecs[7]  = '{1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1, 32'h0000_0008, 32'h1234_5678, 1'b0};
        vecs[9]  = '{1, 32'h0000_0002, ILL,           1'b1};
        vecs[10] = '{1, 32'h0000_1000, ILL,           1'b1};
        for (int i = 0; i < 11; i++) begin
            fetch(vecs[i].d, vecs[i].addr, vecs[i].instr, vecs[i].fault, 1'b0, 32'h0);
        end

        // Write on the capture cycle returns the old word; the refetch sees the new one
        fetch(0, 32'h8, 32'h0BAD_C0DE, 1'b0, 1'b1, 32'h600D_F00D);
        fetch(0, 32'h8, 32'h600D_F00D, 1'b0, 1'b0, 32'h0);
        fetch(1, 32'h8, 32'h1234_5678, 1'b0, 1'b1, 32'h8765_4321);
        fetch(1, 32'h8, 32'h8765_4321, 1'b0, 1'b0, 32'h0);

        // Stall in RESP with a write to the same word, then flush the response away
        req_valid[0] = 1'b1; req_addr[0] = 32'h4; rsp_ready[0] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                wr_en[0] = 1'b1; wr_addr[0] = 32'h4; wr_data[0] = 32'h2222_2222;
            end
            check($sformatf("stall%0d_valid", i), {31'd0, rsp_valid[0]}, 32'd1);
            check($sformatf("stall%0d_instr", i), rsp_instr[0], 32'h1111_1111);
            check($sformatf("stall%0d_ready", i), {31'd0, req_ready[0]}, 32'd0);
            tick();
            wr_en[0] = 1'b0;
        end
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        #1;
        check("flush_resp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("flush_resp_instr", rsp_instr[0], ILL);
        check("flush_resp_ready", {31'd0, req_ready[0]}, 32'd1);
        tick();
        fetch(0, 32'h4, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        fetch(0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'h0);

        // Flush while waiting: no response ever appears
        req_valid[1] = 1'b1; req_addr[1] = 32'h4;
        tick();
        req_valid[1] = 1'b0; flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        no_rsp(1, 6, "flush_wait_no_rsp");
        fetch(1, 32'h4, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);

        // arst while waiting: outputs cleared without a clock edge, fetch discarded
        req_valid[2] = 1'b1; req_addr[2] = 32'h10;
        tick();
        req_valid[2] = 1'b0; arst[2] = 1'b1;
        #1;
        check("arst_wait_ready", {31'd0, req_ready[2]}, 32'd0);
        check("arst_wait_valid", {31'd0, rsp_valid[2]}, 32'd0);
        check("arst_wait_instr", rsp_instr[2], ILL);
        tick();
        arst[2] = 1'b0;
        no_rsp(2, 6, "arst_wait_no_rsp");
        fetch(2, 32'h10, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0);

        // arst while holding a response drops it immediately
        req_valid[0] = 1'b1; req_addr[0] = 32'h0; rsp_ready[0] = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        check("pre_arst_valid", {31'd0, rsp_valid[0]}, 32'd1);
        arst[0] = 1'b1;
        #1;
        check("arst_resp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("arst_resp_instr", rsp_instr[0], ILL);
        tick();
        arst[0] = 1'b0;
        no_rsp(0, 3, "arst_resp_no_rsp");
        fetch(0, 32'h0, 32'h0000_0013, 1'b0, 1'b0, 32'h0);

        // srst while waiting returns to IDLE at the next edge
        req_valid[2] = 1'b1; req_addr[2] = 32'h10;
        tick();
        req_valid[2] = 1'b0; srst[2] = 1'b1;
        tick();
        srst[2] = 1'b0;
        #1;
        check("srst_idle_ready", {31'd0, req_ready[2]}, 32'd1);
        no_rsp(2, 5, "srst_wait_no_rsp");

        // srst blocks a request presented in IDLE
        srst[2] = 1'b1; req_valid[2] = 1'b1; req_addr[2] = 32'h10;
        #1;
        check("srst_ready_low", {31'd0, req_ready[2]}, 32'd0);
        tick();
        srst[2] = 1'b0; req_valid[2] = 1'b0;
        no_rsp(2, 5, "srst_blocks_req");
        fetch(2, 32'h10, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-002 SHALL have parameter INSTR_W, 32, instruction width in bits (multiple of 8, power of two).
REQ-003 SHALL have parameter DEPTH, 1024, number of instruction words stored.
REQ-004 SHALL have parameter WAIT_STATES, 0, extra cycles between request accept and response (0..15).
REQ-005 SHALL have parameter ILLEGAL, 32'h0, word returned on fault and after reset.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: ports clk and arst.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port arst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port srst, input, 1, synchronous active-high clear with the same effect as arst at the next edge.
REQ-010 SHALL have port flush, input, 1, discard the in-flight fetch.
REQ-011 SHALL have port req_valid, input, 1, fetch request.
REQ-012 SHALL have port req_addr, input, ADDR_W, fetch byte address.
REQ-013 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-014 SHALL have port rsp_valid, output, 1, response available.
REQ-015 SHALL have port rsp_instr, output, INSTR_W, fetched word.
REQ-016 SHALL have port rsp_fault, output, 1, misaligned or out-of-range fetch.
REQ-017 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-018 SHALL have port wr_en, input, 1, preload write strobe.
REQ-019 SHALL have port wr_addr, input, ADDR_W, preload byte address (word-aligned).
REQ-020 SHALL have port wr_data, input, INSTR_W, preload data.

Function
REQ-021 SHALL run an FSM with states IDLE, WAIT and RESP, one fetch outstanding at most.
REQ-022 SHALL drive req_ready = 1 only in IDLE with flush low.
REQ-023 On accept in IDLE SHALL latch req_addr, go to WAIT if WAIT_STATES>0, else to RESP.
REQ-024 In WAIT SHALL count WAIT_STATES cycles, then go to RESP; accept-to-rsp_valid latency is exactly 1+WAIT_STATES cycles.
REQ-025 SHALL read memory on the cycle of the transition into RESP; a wr_en to the same word on that cycle returns the old data (read-before-write).
REQ-026 In RESP SHALL hold rsp_valid, rsp_instr and rsp_fault stable until rsp_ready is high, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 SHALL flag a fault when the low log2(INSTR_W/8) address bits are nonzero or the word index is >= DEPTH; a faulting fetch SHALL return rsp_instr = ILLEGAL, rsp_fault = 1, with normal latency.
REQ-028 flush in WAIT or RESP SHALL return the FSM to IDLE next cycle with no response; flush has priority over rsp_ready and req_valid.
REQ-029 wr_en SHALL write wr_data at index wr_addr/(INSTR_W/8) in any state; out-of-range or misaligned writes SHALL be ignored.
REQ-030 Outside RESP, rsp_valid SHALL be 0 and rsp_instr SHALL be ILLEGAL with rsp_fault 0.

Reset
REQ-031 arst SHALL immediately force IDLE, wait counter 0, rsp_valid 0, rsp_fault 0, rsp_instr ILLEGAL and req_ready 0 while asserted.
REQ-032 srst SHALL produce the same state at the next rising edge, with priority over flush, requests and responses.
REQ-033 Reset mid-fetch SHALL discard the fetch with no response; memory contents SHALL NOT be altered by any reset.

Structure
REQ-034 Package imem_pkg SHALL hold the FSM state typedef and the maximum wait-state constant.
REQ-035 Storage SHALL be a sub-module imem_ram (DEPTH x INSTR_W, one read port, one write port, read-before-write).

Verification
REQ-036 WAIT_STATES=0, preload 0x00000013 at 0x0; fetch 0x0 -> rsp_valid next cycle, instr 0x00000013, fault 0.
REQ-037 WAIT_STATES=3, fetch 0x4 holding 0xDEADBEEF -> rsp_valid exactly 4 cycles after accept, req_ready low throughout.
REQ-038 Fetch 0x2, then fetch DEPTH*4 -> both return ILLEGAL with rsp_fault=1.
REQ-039 rsp_ready held low 5 cycles -> response stable; flush in RESP -> rsp_valid 0 next cycle, no data lost elsewhere.
REQ-040 WAIT_STATES=2, assert arst in WAIT -> outputs reset immediately, no response after release; memory word unchanged on refetch.
REQ-041 wr_en to 0x8 on the read-capture cycle of a fetch to 0x8 -> old value returned; refetch returns new value.
